setting_controller: RTL

- Menu controller for the pre-game settings screen; sequences which setting is shown on the setting tube display and edits its value.
- Takes four debounced level buttons; produces the display-select index `cur_set` and the selected value `number` that feed the tube display.
- Holds a working copy and a committed copy of four settings: players, countdown time, positive score, negative score.
- Committed values go to the game/answer controller only on confirm.

---
 rtl/setting_pkg.sv | 29 ++
 rtl/setting_controller_button_repeat.sv | 61 ++++++
 rtl/setting_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/setting_pkg.sv
// Shared definitions for the pre-game settings menu: field indices, menu states,
// value width and the wrap-around step used when editing a setting.
package setting_pkg;

    localparam int VAL_W = 6;

    localparam logic [1:0] SET_PLAYERS = 2'd0;
    localparam logic [1:0] SET_TIME    = 2'd1;
    localparam logic [1:0] SET_POS     = 2'd2;
    localparam logic [1:0] SET_NEG     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // One step up or down inside [lo, hi], wrapping at either end.
    function automatic logic [VAL_W-1:0] step_wrap(input logic [VAL_W-1:0] val,
                                                   input logic [VAL_W-1:0] lo,
                                                   input logic [VAL_W-1:0] hi,
                                                   input logic             up);
        logic [VAL_W-1:0] res;
        if (up) res = (val >= hi) ? lo : val + 1'b1;
        else    res = (val <= lo) ? hi : val - 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/setting_controller_button_repeat.sv
// Rising-edge detector with hold-to-repeat for one debounced level button.
// step pulses on the edge, after HOLD_CYCLES of holding, then every REPEAT_CYCLES.
module button_repeat #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clear,
    output logic rise,
    output logic step
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             hit;

    assign rise = btn & ~btn_q;

    // cnt_q counts cycles since the last step; rep_q selects hold vs repeat period.
    always_comb begin
        hit   = rep_q ? (cnt_q == CNT_W'(REPEAT_CYCLES)) : (cnt_q == CNT_W'(HOLD_CYCLES));
        cnt_d = cnt_q;
        rep_d = rep_q;
        step  = 1'b0;
        if (!btn) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise) begin
            step  = 1'b1;
            cnt_d = clear ? '0 : CNT_W'(1);
            rep_d = 1'b0;
        end else if (clear) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (hit) begin
            step  = 1'b1;
            cnt_d = CNT_W'(1);
            rep_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= btn;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/setting_controller.sv
// Pre-game settings menu: selects which setting the tube display shows, edits a
// working copy with the buttons and commits it to the cfg_* outputs on confirm.
module setting_controller
    import setting_pkg::*;
#(
    parameter int P_MIN         = 1,
    parameter int P_MAX         = 8,
    parameter int P_DEF         = 4,
    parameter int T_MIN         = 5,
    parameter int T_MAX         = 60,
    parameter int T_DEF         = 20,
    parameter int S_MAX         = 63,
    parameter int POS_DEF       = 10,
    parameter int NEG_DEF       = 5,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_confirm,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [1:0] cur_set,
    output logic [5:0] number,
    output logic       edit_active,
    output logic       config_done,
    output logic [5:0] cfg_players,
    output logic [5:0] cfg_time,
    output logic [5:0] cfg_pos,
    output logic [5:0] cfg_neg
);
    if (!(P_MIN <= P_DEF && P_DEF <= P_MAX && P_MAX <= 63 &&
          T_MIN <= T_DEF && T_DEF <= T_MAX && T_MAX <= 63 &&
          POS_DEF <= S_MAX && NEG_DEF <= S_MAX && S_MAX <= 63 &&
          HOLD_CYCLES >= 1 && REPEAT_CYCLES >= 1)) begin : g_bad_params
        $error("setting_controller: illegal parameter set");
    end

    state_e           state_q;
    logic [1:0]       cur_set_q, nxt_set;
    logic [VAL_W-1:0] number_q;
    logic             edit_q, done_q;
    logic             confirm_q, next_q;
    logic [VAL_W-1:0] work_q [4];
    logic [VAL_W-1:0] cfg_q  [4];

    logic             ev_conf, ev_next;
    logic             inc_rise, inc_step, dec_rise, dec_step;
    logic [VAL_W-1:0] lo, hi, step_val;

    assign ev_conf = btn_confirm & ~confirm_q;
    assign ev_next = btn_next & ~next_q;
    assign nxt_set = cur_set_q + 2'd1;

    button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn(btn_inc), .clear(ev_conf | ev_next | dec_rise),
        .rise(inc_rise), .step(inc_step)
    );

    button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .btn(btn_dec), .clear(ev_conf | ev_next | inc_rise),
        .rise(dec_rise), .step(dec_step)
    );

    always_comb begin
        lo = '0;
        hi = VAL_W'(S_MAX);
        case (cur_set_q)
            SET_PLAYERS: begin lo = VAL_W'(P_MIN); hi = VAL_W'(P_MAX); end
            SET_TIME:    begin lo = VAL_W'(T_MIN); hi = VAL_W'(T_MAX); end
            default:     begin lo = '0;            hi = VAL_W'(S_MAX); end
        endcase
        step_val = step_wrap(work_q[cur_set_q], lo, hi, inc_step);
    end

    // Priority inside EDIT: confirm, then next, then a non-cancelling inc/dec step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_set_q <= SET_PLAYERS;
            number_q  <= VAL_W'(P_DEF);
            edit_q    <= 1'b0;
            done_q    <= 1'b0;
            confirm_q <= 1'b0;
            next_q    <= 1'b0;
            work_q[0] <= VAL_W'(P_DEF);
            work_q[1] <= VAL_W'(T_DEF);
            work_q[2] <= VAL_W'(POS_DEF);
            work_q[3] <= VAL_W'(NEG_DEF);
            cfg_q[0]  <= VAL_W'(P_DEF);
            cfg_q[1]  <= VAL_W'(T_DEF);
            cfg_q[2]  <= VAL_W'(POS_DEF);
            cfg_q[3]  <= VAL_W'(NEG_DEF);
        end else begin
            confirm_q <= btn_confirm;
            next_q    <= btn_next;
            case (state_q)
                ST_IDLE, ST_LOCKED: begin
                    if (ev_conf) begin
                        state_q   <= ST_EDIT;
                        cur_set_q <= SET_PLAYERS;
                        number_q  <= work_q[SET_PLAYERS];
                        edit_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ST_EDIT: begin
                    if (ev_conf) begin
                        state_q <= ST_LOCKED;
                        edit_q  <= 1'b0;
                        done_q  <= 1'b1;
                        for (int k = 0; k < 4; k++) cfg_q[k] <= work_q[k];
                    end else if (ev_next) begin
                        cur_set_q <= nxt_set;
                        number_q  <= work_q[nxt_set];
                    end else if (inc_step ^ dec_step) begin
                        work_q[cur_set_q] <= step_val;
                        number_q          <= step_val;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    edit_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cur_set     = cur_set_q;
    assign number      = number_q;
    assign edit_active = edit_q;
    assign config_done = done_q;
    assign cfg_players = cfg_q[SET_PLAYERS];
    assign cfg_time    = cfg_q[SET_TIME];
    assign cfg_pos     = cfg_q[SET_POS];
    assign cfg_neg     = cfg_q[SET_NEG];

endmodule
